ifetch_mem_arbiter: RTL and testbench
=====================================

Name: ifetch_mem_arbiter

Overview:
Arbitrates the single shared DRAM/cache port between the instruction-fetch path and the MEM-stage data path of the pipelined CPU. Decodes each fetch address into the ROM or DRAM channel and drives if_channel_sel, dram_data_ready and dram_dout toward the fetch-ready stage. Generates the stall requests that hold IF and MEM while the port is busy. Handles pipeline flush of an in-flight fetch without corrupting the shared port.

Parameters:
ROM_BASE, 64'h0000_0000_0000_0000, first byte address of the instruction ROM window
ROM_SIZE, 64'h0000_0000_0001_0000, ROM window size in bytes (power of two)
STARVE_LIMIT, 4, consecutive MEM grants allowed while a DRAM fetch waits; width 3 bits sufficient

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush; cancels any fetch not yet returned
if_req  in  1  fetch request valid
if_addr  in  64  fetch PC (4-byte aligned)
mem_req  in  1  data access request valid
mem_we  in  1  1 = store, 0 = load
mem_addr  in  64  data byte address
mem_wdata  in  64  store data
mem_wmask  in  8  store byte mask
if_channel_sel  out  1  1 = fetch served from DRAM, 0 = from ROM
dram_data_ready  out  1  fetch data valid this cycle
dram_dout  out  32  fetched instruction
mem_ready  out  1  data access complete this cycle
mem_rdata  out  64  load data
if_stall  out  1  hold fetch stages
mem_stall  out  1  hold MEM stage
port_req  out  1  request to DRAM/cache
port_we  out  1  write enable to DRAM/cache
port_addr  out  64  address to DRAM/cache
port_wdata  out  64  write data
port_wmask  out  8  write mask
port_ready  in  1  single-cycle completion pulse from DRAM/cache
port_rdata  in  64  read data, valid with port_ready

Behaviour:
- Reset (async): state IDLE, port_req=0, port_we=0, port_addr/wdata/wmask=0, starve counter=0. All outputs 0 except if_channel_sel, which is combinational. A transaction interrupted by reset is abandoned. The memory side must tolerate a dropped request.
- if_channel_sel = !(if_addr in [ROM_BASE, ROM_BASE+ROM_SIZE)). This decode is combinational.
- ROM fetches never touch the port and never stall.
- FSM states: IDLE, SERVE_IF, SERVE_MEM, DRAIN.
- IDLE exit conditions:
  - Candidate IF = if_req && if_channel_sel && !flush.
  - If mem_req and candidate IF are both present, MEM wins unless starve counter == STARVE_LIMIT, in which case IF wins.
  - Winner's address, we and data are registered into port_*. port_req=1 from the next cycle. Next state is SERVE_IF or SERVE_MEM.
- Port handshake: port_req and port_* stay stable until port_ready. Grant-to-first-possible-completion latency is 1 cycle.
- SERVE_IF completes on port_ready:
  - dram_data_ready=1 that same cycle (combinational).
  - dram_dout = port_rdata[63:32] if latched addr[2] else [31:0].
  - port_req drops on the next edge. State returns to IDLE. No back-to-back grant without passing through IDLE.
- SERVE_MEM completes on port_ready: mem_ready=1 and mem_rdata=port_rdata that cycle. State returns to IDLE.
- Flush while in SERVE_IF, or in the same cycle as the grant edge: go to DRAIN. port_req stays high until port_ready. dram_data_ready stays 0. Then return to IDLE.
- Flush coincident with port_ready in SERVE_IF: data is suppressed and state goes to IDLE.
- Flush does not affect SERVE_MEM.
- Starve counter:
  - Increments when MEM is granted while candidate IF is present. Saturates at STARVE_LIMIT.
  - Clears when IF is granted or when candidate IF is absent in IDLE.
- Stalls (combinational):
  - if_stall = if_req && if_channel_sel && !dram_data_ready.
  - mem_stall = mem_req && !mem_ready.
- dram_data_ready and mem_ready are never high in the same cycle.

Decomposition:
- Shared package: arb_state_t enum (IDLE, SERVE_IF, SERVE_MEM, DRAIN), ROM_BASE/ROM_SIZE defaults, width constants. The package goes into Modules/defines.v space.
- One natural sub-module: ifetch_addr_decode (combinational ROM-window decode). It is reused by the fetch stages.

Test Plan:
- ROM fetch at 0x100, no mem_req -> if_channel_sel=0, port_req never asserted, if_stall=0.
- DRAM fetch at 0x8000_0004, port_ready 3 cycles after port_req, port_rdata=64'hAAAA_BBBB_CCCC_DDDD -> dram_data_ready pulses once, dram_dout=32'hAAAA_BBBB, if_stall high until then.
- Simultaneous mem load 0x8000_1000 and DRAM fetch -> MEM served first, mem_ready with data, IF granted on the following IDLE pass.
- Continuous mem_req with pending DRAM fetch, STARVE_LIMIT=4 -> exactly 4 MEM grants, then IF grant, counter back to 0.
- Flush 1 cycle after IF grant, port_ready 2 cycles later -> state DRAIN, dram_data_ready never asserted, next grant only after port_ready.
- Reset asserted mid-SERVE_MEM -> port_req=0 immediately (async), state IDLE, mem_ready stays 0.

Source files
------------

// File: rtl/ifetch_mem_arbiter_pkg.sv
// Shared types and constants for the fetch/MEM arbiter of the shared DRAM/cache port
// and for the fetch-stage ROM window decode.
package ifetch_mem_arbiter_pkg;

  localparam int XLEN     = 64;
  localparam int INSN_W   = 32;
  localparam int MASK_W   = 8;
  localparam int STARVE_W = 3;

  localparam logic [XLEN-1:0]     ROM_BASE_DEF     = 64'h0000_0000_0000_0000;
  localparam logic [XLEN-1:0]     ROM_SIZE_DEF     = 64'h0000_0000_0001_0000;
  localparam logic [STARVE_W-1:0] STARVE_LIMIT_DEF = 3'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2,
    DRAIN     = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ifetch_addr_decode.sv
// Combinational decode of a fetch address against the instruction ROM window.
// Shared with the fetch stages so every user agrees on the same window.
module ifetch_addr_decode
  import ifetch_mem_arbiter_pkg::*;
#(
  parameter logic [XLEN-1:0] ROM_BASE = ROM_BASE_DEF,
  parameter logic [XLEN-1:0] ROM_SIZE = ROM_SIZE_DEF
) (
  input  logic [XLEN-1:0] addr,
  output logic            in_rom
);

  logic [XLEN-1:0] offset;

  // Offset compare avoids overflow of ROM_BASE + ROM_SIZE at the top of the map.
  always_comb begin
    offset = addr - ROM_BASE;
    in_rom = (addr >= ROM_BASE) && (offset < ROM_SIZE);
  end

endmodule

// File: rtl/ifetch_mem_arbiter.sv
// Arbiter for the single DRAM/cache port shared by instruction fetch and the MEM stage.
// ROM fetches bypass the port; DRAM fetches compete with MEM under a starvation guard.
module ifetch_mem_arbiter
  import ifetch_mem_arbiter_pkg::*;
#(
  parameter logic [XLEN-1:0]     ROM_BASE     = ROM_BASE_DEF,
  parameter logic [XLEN-1:0]     ROM_SIZE     = ROM_SIZE_DEF,
  parameter logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              if_req,
  input  logic [63:0]       if_addr,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [63:0]       mem_addr,
  input  logic [63:0]       mem_wdata,
  input  logic [7:0]        mem_wmask,
  output logic              if_channel_sel,
  output logic              dram_data_ready,
  output logic [31:0]       dram_dout,
  output logic              mem_ready,
  output logic [63:0]       mem_rdata,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              port_req,
  output logic              port_we,
  output logic [63:0]       port_addr,
  output logic [63:0]       port_wdata,
  output logic [7:0]        port_wmask,
  input  logic              port_ready,
  input  logic [63:0]       port_rdata
);

  arb_state_t          state_q, state_d;
  logic                port_req_q, port_req_d;
  logic                port_we_q, port_we_d;
  logic [XLEN-1:0]     port_addr_q, port_addr_d;
  logic [XLEN-1:0]     port_wdata_q, port_wdata_d;
  logic [MASK_W-1:0]   port_wmask_q, port_wmask_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic in_rom;
  logic cand_if;
  logic grant_mem;
  logic grant_if;

  ifetch_addr_decode #(
    .ROM_BASE (ROM_BASE),
    .ROM_SIZE (ROM_SIZE)
  ) u_decode (
    .addr   (if_addr),
    .in_rom (in_rom)
  );

  assign if_channel_sel = !in_rom;

  // MEM normally wins; a fetch that has waited STARVE_LIMIT MEM grants takes the port.
  always_comb begin
    cand_if   = if_req && if_channel_sel && !flush;
    grant_mem = (state_q == IDLE) && mem_req && (!cand_if || (starve_q != STARVE_LIMIT));
    grant_if  = (state_q == IDLE) && cand_if && !grant_mem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          state_d = SERVE_MEM;
        end else if (grant_if) begin
          state_d = SERVE_IF;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_IF: begin
        if (port_ready) begin
          state_d = IDLE;
        end else if (flush) begin
          state_d = DRAIN;
        end else begin
          state_d = SERVE_IF;
        end
      end
      SERVE_MEM: state_d = port_ready ? IDLE : SERVE_MEM;
      DRAIN:     state_d = port_ready ? IDLE : DRAIN;
      default:   state_d = IDLE;
    endcase
  end

  // Port fields are captured only on a grant and held until the completion pulse.
  always_comb begin
    port_req_d   = port_req_q;
    port_we_d    = port_we_q;
    port_addr_d  = port_addr_q;
    port_wdata_d = port_wdata_q;
    port_wmask_d = port_wmask_q;
    starve_d     = starve_q;
    if (grant_mem) begin
      port_req_d   = 1'b1;
      port_we_d    = mem_we;
      port_addr_d  = mem_addr;
      port_wdata_d = mem_wdata;
      port_wmask_d = mem_wmask;
    end else if (grant_if) begin
      port_req_d   = 1'b1;
      port_we_d    = 1'b0;
      port_addr_d  = if_addr;
      port_wdata_d = 64'h0;
      port_wmask_d = 8'h00;
    end else if (port_ready) begin
      port_req_d   = 1'b0;
    end else begin
      port_req_d   = port_req_q;
    end
    if (state_q == IDLE) begin
      if (grant_if || !cand_if) begin
        starve_d = 3'd0;
      end else if (grant_mem && (starve_q != STARVE_LIMIT)) begin
        starve_d = starve_q + 3'd1;
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_req_q   <= 1'b0;
      port_we_q    <= 1'b0;
      port_addr_q  <= 64'h0;
      port_wdata_q <= 64'h0;
      port_wmask_q <= 8'h00;
      starve_q     <= 3'd0;
    end else begin
      port_req_q   <= port_req_d;
      port_we_q    <= port_we_d;
      port_addr_q  <= port_addr_d;
      port_wdata_q <= port_wdata_d;
      port_wmask_q <= port_wmask_d;
      starve_q     <= starve_d;
    end
  end

  // Data outputs are forced to zero outside their ready cycle so idle buses stay quiet.
  always_comb begin
    dram_data_ready = (state_q == SERVE_IF) && port_ready && !flush;
    mem_ready       = (state_q == SERVE_MEM) && port_ready;
    if (dram_data_ready) begin
      dram_dout = port_addr_q[2] ? port_rdata[63:32] : port_rdata[31:0];
    end else begin
      dram_dout = 32'h0;
    end
    if (mem_ready) begin
      mem_rdata = port_rdata;
    end else begin
      mem_rdata = 64'h0;
    end
    if_stall   = if_req && if_channel_sel && !dram_data_ready;
    mem_stall  = mem_req && !mem_ready;
    port_req   = port_req_q;
    port_we    = port_we_q;
    port_addr  = port_addr_q;
    port_wdata = port_wdata_q;
    port_wmask = port_wmask_q;
  end

endmodule

// File: tb/tb_ifetch_mem_arbiter.sv
// Self-checking bench for ifetch_mem_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_ifetch_mem_arbiter;

  localparam logic [63:0] ROM_BASE = 64'h0000_0000_0000_0000;
  localparam logic [63:0] ROM_SIZE = 64'h0000_0000_0001_0000;
  localparam int          LIMIT    = 4;

  logic        clk, reset, flush;
  logic        if_req, mem_req, mem_we;
  logic [63:0] if_addr, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        if_channel_sel, dram_data_ready, mem_ready, if_stall, mem_stall;
  logic [31:0] dram_dout;
  logic [63:0] mem_rdata;
  logic        port_req, port_we, port_ready;
  logic [63:0] port_addr, port_wdata, port_rdata;
  logic [7:0]  port_wmask;

  ifetch_mem_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .if_channel_sel(if_channel_sel), .dram_data_ready(dram_data_ready),
    .dram_dout(dram_dout), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_wmask(port_wmask),
    .port_ready(port_ready), .port_rdata(port_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: at most one outstanding port transaction, owned by IF or MEM.
  bit          m_busy, m_is_if, m_cancel;
  bit          m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  int          m_starve;
  int          lat_left;
  int          force_lat = -1;
  bit          rdata_fixed = 1'b0;
  logic [63:0] rdata_val = 64'h0;
  int          ddr_pulses, memr_pulses, stall_cycles;
  logic [31:0] last_dout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_in_rom(input logic [63:0] a);
    return (a >= ROM_BASE) && (a < ROM_BASE + ROM_SIZE);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_is_if = 1'b0; m_cancel = 1'b0; m_we = 1'b0;
    m_addr = 64'h0; m_wdata = 64'h0; m_wmask = 8'h00; m_starve = 0; lat_left = 0;
  endtask

  // One clock: inputs were set at the preceding negedge; ends at the next negedge.
  task automatic cycle();
    bit          sel_e, ddr_e, memr_e, cand;
    logic [31:0] dout_e;
    port_ready = m_busy && (lat_left == 0);
    port_rdata = rdata_fixed ? rdata_val : {$urandom(), $urandom()};
    #1;
    sel_e  = !exp_in_rom(if_addr);
    ddr_e  = port_ready && m_is_if && !m_cancel && !flush;
    memr_e = port_ready && !m_is_if;
    dout_e = !ddr_e ? 32'h0 : (m_addr[2] ? port_rdata[63:32] : port_rdata[31:0]);
    check("if_channel_sel", 64'(if_channel_sel), 64'(sel_e));
    check("dram_data_ready", 64'(dram_data_ready), 64'(ddr_e));
    check("mem_ready", 64'(mem_ready), 64'(memr_e));
    check("dram_dout", 64'(dram_dout), 64'(dout_e));
    check("mem_rdata", mem_rdata, memr_e ? port_rdata : 64'h0);
    check("if_stall", 64'(if_stall), 64'(if_req && sel_e && !ddr_e));
    check("mem_stall", 64'(mem_stall), 64'(mem_req && !memr_e));
    if (dram_data_ready) begin
      ddr_pulses++;
      last_dout = dram_dout;
    end
    if (mem_ready) memr_pulses++;
    if (if_stall) stall_cycles++;
    @(posedge clk);
    if (m_busy) begin
      if (m_is_if && flush) m_cancel = 1'b1;
      if (port_ready) m_busy = 1'b0;
      else lat_left--;
    end else begin
      cand = if_req && sel_e && !flush;
      if (mem_req && !(cand && m_starve == LIMIT)) begin
        m_busy = 1'b1; m_is_if = 1'b0; m_cancel = 1'b0;
        m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata; m_wmask = mem_wmask;
        m_starve = cand ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else if (cand) begin
        m_busy = 1'b1; m_is_if = 1'b1; m_cancel = 1'b0; m_we = 1'b0; m_addr = if_addr;
        m_starve = 0;
      end else begin
        m_starve = 0;
      end
      if (m_busy) lat_left = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
    end
    #1;
    check("port_req", 64'(port_req), 64'(m_busy));
    if (m_busy) begin
      check("port_addr", port_addr, m_addr);
      check("port_we", 64'(port_we), 64'(m_we));
      if (!m_is_if) begin
        check("port_wdata", port_wdata, m_wdata);
        check("port_wmask", 64'(port_wmask), 64'(m_wmask));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; if_req = 1'b0; if_addr = 64'h0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = 64'h0; mem_wdata = 64'h0; mem_wmask = 8'h00;
  endtask

  initial begin
    idle_inputs();
    port_ready = 1'b0; port_rdata = 64'h0;
    model_reset();
    ddr_pulses = 0; memr_pulses = 0; stall_cycles = 0; last_dout = 32'h0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_port_req", 64'(port_req), 64'h0);
    check("rst_port_addr", port_addr, 64'h0);
    check("rst_port_wdata", port_wdata, 64'h0);
    check("rst_port_wmask", 64'(port_wmask), 64'h0);
    check("rst_port_we", 64'(port_we), 64'h0);
    check("rst_ready", 64'({dram_data_ready, mem_ready, if_stall, mem_stall}), 64'h0);
    reset = 1'b0;

    // ROM fetch never touches the port
    if_req = 1'b1; if_addr = 64'h100;
    repeat (5) cycle();
    check("rom_sel", 64'(if_channel_sel), 64'h0);
    idle_inputs();
    cycle();

    // DRAM fetch, 3-cycle latency, upper word selected by addr[2]
    force_lat = 3; rdata_fixed = 1'b1; rdata_val = 64'hAAAA_BBBB_CCCC_DDDD;
    ddr_pulses = 0; stall_cycles = 0;
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0004;
    for (int i = 0; i < 12 && ddr_pulses == 0; i++) cycle();
    idle_inputs();
    cycle(); cycle();
    check("dram_pulses", 64'(ddr_pulses), 64'd1);
    check("dram_dout_hi", 64'(last_dout), 64'h0000_0000_AAAA_BBBB);
    check("dram_stall_cycles", 64'(stall_cycles), 64'd4);
    rdata_fixed = 1'b0;

    // Simultaneous MEM load and DRAM fetch: MEM first
    force_lat = 1; ddr_pulses = 0; memr_pulses = 0;
    mem_req = 1'b1; mem_addr = 64'h0000_0000_8000_1000;
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_2000;
    for (int i = 0; i < 12 && ddr_pulses == 0; i++) begin
      cycle();
      if (memr_pulses > 0) mem_req = 1'b0;
    end
    check("mem_before_if", 64'(memr_pulses), 64'd1);
    check("if_after_mem", 64'(ddr_pulses), 64'd1);
    idle_inputs();
    cycle();

    // Starvation guard: exactly LIMIT MEM grants, then IF, twice in a row
    force_lat = 0;
    mem_req = 1'b1; mem_addr = 64'h0000_0000_9000_0000; mem_wdata = 64'h1234; mem_wmask = 8'h0F;
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0040;
    for (int r = 0; r < 2; r++) begin
      ddr_pulses = 0; memr_pulses = 0;
      for (int i = 0; i < 40 && ddr_pulses == 0; i++) cycle();
      check("starve_if_grant", 64'(ddr_pulses), 64'd1);
      check("starve_mem_grants", 64'(memr_pulses), 64'(LIMIT));
    end
    idle_inputs();
    repeat (2) cycle();

    // Flush one cycle after IF grant: drain without data, MEM waits for completion
    force_lat = 3; ddr_pulses = 0;
    if_req = 1'b1; if_addr = 64'h0000_0000_8000_0100;
    cycle();
    if_req = 1'b0; flush = 1'b1; mem_req = 1'b1; mem_addr = 64'h0000_0000_8000_0200;
    cycle();
    flush = 1'b0;
    repeat (6) cycle();
    check("flush_no_data", 64'(ddr_pulses), 64'd0);
    idle_inputs();
    repeat (5) cycle();

    // Asynchronous reset in the middle of a MEM transaction
    force_lat = 6; memr_pulses = 0;
    mem_req = 1'b1; mem_addr = 64'h0000_0000_8000_0300;
    cycle(); cycle();
    port_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_port_req", 64'(port_req), 64'h0);
    check("async_rst_port_addr", port_addr, 64'h0);
    check("async_rst_mem_ready", 64'(mem_ready), 64'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    repeat (3) cycle();
    check("rst_mem_abandoned", 64'(memr_pulses), 64'd0);

    // Random traffic against the model
    force_lat = -1;
    for (int i = 0; i < 2000; i++) begin
      flush   = ($urandom_range(0, 7) == 0);
      if_req  = $urandom_range(0, 1);
      if_addr = ($urandom_range(0, 2) == 0) ? (64'($urandom_range(0, 16383)) << 2)
                : {32'h0, 32'h8000_0000 | ($urandom() & 32'h0FFF_FFFC)};
      mem_req   = $urandom_range(0, 1);
      mem_we    = $urandom_range(0, 1);
      mem_addr  = {$urandom(), $urandom()};
      mem_wdata = {$urandom(), $urandom()};
      mem_wmask = 8'($urandom());
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
